leaf_out_arbiter: RTL

Shares one BFT output link among the NUM_OUT_PORTS user output streams of a leaf. It sits between the user kernel's `din_leaf_user2interface_*` / `vld_user2interface_*` / `ack_interface2user_*` ports and the leaf's 49-bit BFT output. Each cycle it performs a credit-gated round-robin grant, stamps the granted word with a configured destination (leaf, port) and a per-port write address, and registers the packet toward the link. Credits mirror free space in the remote BRAM and are replenished by freespace update packets.

---
 rtl/leaf_out_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/leaf_out_arbiter.sv
`timescale 1ns/1ps
// Purpose: credit-gated round-robin arbiter that stamps user words with (leaf, port, addr) onto one BFT link.
// Latency: 1 cycle from grant (combinational ack_user) to the packet appearing on pkt_out.
// Backpressure: grants stall while pkt_out is valid and pkt_ready is low, during resend, or when a port has no credit.
//
// Ports:
//   clk, reset_n                          clock, async active-low reset
//   cfg_wr_en, cfg_port, cfg_dest         per-port destination {leaf, port} write
//   din_user, vld_user, ack_user          user streams 1..NUM_OUT_PORTS, one-hot consume strobe
//   credit_upd_vld, credit_upd_port       freespace update, returns FREESPACE_UPDATE_SIZE credits
//   pkt_out, pkt_ready, resend            link side {valid, leaf, port, addr, payload}
//   grant_port                            last granted port number, 0 until the first grant
module leaf_out_arbiter #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_OUT_PORTS         = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    cfg_wr_en,
    input  logic [NUM_PORT_BITS-1:0]                cfg_port,
    input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0]  cfg_dest,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_user,
    input  logic [NUM_OUT_PORTS-1:0]                vld_user,
    output logic [NUM_OUT_PORTS-1:0]                ack_user,
    input  logic                                    credit_upd_vld,
    input  logic [NUM_PORT_BITS-1:0]                credit_upd_port,
    output logic [PACKET_BITS-1:0]                  pkt_out,
    input  logic                                    pkt_ready,
    input  logic                                    resend,
    output logic [NUM_PORT_BITS-1:0]                grant_port
);

    localparam int DEST_BITS   = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int CREDIT_BITS = NUM_ADDR_BITS + 1;
    localparam int SUM_BITS    = CREDIT_BITS + 1;
    localparam int IDX_BITS    = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    localparam int CREDIT_MAX_INT = 2 ** NUM_ADDR_BITS;

    localparam logic [CREDIT_BITS-1:0]   CREDIT_MAX = CREDIT_BITS'(CREDIT_MAX_INT);
    localparam logic [SUM_BITS-1:0]      SUM_MAX    = SUM_BITS'(CREDIT_MAX_INT);
    localparam logic [SUM_BITS-1:0]      UPD_AMT    = SUM_BITS'(FREESPACE_UPDATE_SIZE);
    localparam logic [NUM_PORT_BITS-1:0] MAX_PORT   = NUM_PORT_BITS'(NUM_OUT_PORTS);

    // Per-port state, index 0 holds user port 1.
    logic                     cfg_valid [NUM_OUT_PORTS];
    logic [DEST_BITS-1:0]     dest      [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit    [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] addr      [NUM_OUT_PORTS];

    logic [NUM_PORT_BITS-1:0] rr_last;

    logic [PAYLOAD_BITS-1:0]  word        [NUM_OUT_PORTS];
    logic [SUM_BITS-1:0]      credit_sum  [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit_nxt  [NUM_OUT_PORTS];
    logic [NUM_OUT_PORTS-1:0] eligible;
    logic [NUM_OUT_PORTS-1:0] gnt_sel;
    logic [NUM_OUT_PORTS-1:0] cfg_sel;
    logic [NUM_OUT_PORTS-1:0] upd_sel;
    logic                     out_free;
    logic                     can_grant;
    logic                     grant_vld;
    logic [IDX_BITS-1:0]      grant_idx;
    logic [NUM_PORT_BITS-1:0] grant_num;

    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            word[i]     = din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            eligible[i] = vld_user[i] & cfg_valid[i] & (credit[i] != '0);
            // Port numbers 0 and > NUM_OUT_PORTS never match any slot, so they are ignored.
            cfg_sel[i]  = cfg_wr_en & (cfg_port == NUM_PORT_BITS'(i + 1));
            upd_sel[i]  = credit_upd_vld & (credit_upd_port == NUM_PORT_BITS'(i + 1));
        end
    end

    // Round-robin search starting at the port after rr_last (1-based), wrapping to port 1.
    always_comb begin
        int idx;
        idx       = 0;
        out_free  = ~pkt_out[PACKET_BITS-1] | pkt_ready;
        can_grant = out_free & ~resend;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
            idx = (int'(rr_last) - 1 + k) % NUM_OUT_PORTS;
            if (!grant_vld && can_grant && eligible[idx]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_BITS'(idx);
            end
        end
        grant_num = NUM_PORT_BITS'(grant_idx) + NUM_PORT_BITS'(1);
    end

    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            gnt_sel[i] = grant_vld & (grant_idx == IDX_BITS'(i));
        end
    end

    assign ack_user = gnt_sel;

    // Grant and update in the same cycle net to +63; the sum is one bit wider so saturation sees the overflow.
    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_sum[i] = {1'b0, credit[i]}
                          - (gnt_sel[i] ? SUM_BITS'(1) : '0)
                          + (upd_sel[i] ? UPD_AMT : '0);
            credit_nxt[i] = (credit_sum[i] > SUM_MAX) ? CREDIT_MAX : credit_sum[i][CREDIT_BITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                cfg_valid[i] <= 1'b0;
                dest[i]      <= '0;
                credit[i]    <= CREDIT_MAX;
                addr[i]      <= '0;
            end
            pkt_out    <= '0;
            rr_last    <= MAX_PORT;
            grant_port <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (cfg_sel[i]) begin
                    cfg_valid[i] <= 1'b1;
                    dest[i]      <= cfg_dest;
                end
                credit[i] <= credit_nxt[i];
                if (gnt_sel[i]) begin
                    addr[i] <= addr[i] + NUM_ADDR_BITS'(1);
                end
            end
            if (grant_vld) begin
                pkt_out    <= {1'b1, dest[grant_idx], addr[grant_idx], word[grant_idx]};
                rr_last    <= grant_num;
                grant_port <= grant_num;
            end else if (out_free && !resend) begin
                // Link took the packet (or none was pending); only the valid bit drops.
                pkt_out[PACKET_BITS-1] <= 1'b0;
            end
        end
    end

endmodule
